// File: rtl/coherent_acc_buffer.sv
// Coherent accumulation buffer: averages N = 2^NB frames of M signed samples
// into an M-entry accumulator array. A run clears every bin, then sums samples
// bin by bin for N frames, and then holds the results for read-out with a
// single-cycle read latency.
module coherent_acc_buffer #(
   parameter int Q  = 32,
   parameter int M  = 128,
   parameter int NB = 4,
   localparam int AW     = $clog2(M),
   localparam int AW_ACC = Q + NB
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     x_valid,
   input  logic signed [Q-1:0]      x,
   output logic                     busy,
   output logic                     done,
   input  logic                     rd_req,
   input  logic [AW-1:0]            rd_addr,
   output logic                     rd_valid,
   output logic signed [AW_ACC-1:0] rd_data
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_ACC   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                     state_r;
   state_t                     state_s;
   logic [AW-1:0]              idx_r;
   logic [NB-1:0]              frame_r;
   logic                       busy_r;
   logic                       done_r;
   logic                       rd_valid_r;
   logic signed [AW_ACC-1:0]   rd_data_r;
   logic signed [AW_ACC-1:0]   mem_r [M];

   logic                       last_idx_s;
   logic                       last_frame_s;
   logic                       busy_s;
   logic                       done_s;
   logic                       clear_we_s;
   logic                       acc_we_s;
   logic                       rd_fire_s;
   logic signed [AW_ACC-1:0]   ext_x_s;

   // The bin index doubles as the clear pointer, so one counter serves both phases.
   assign last_idx_s   = (idx_r == AW'(M - 1));
   assign last_frame_s = (frame_r == {NB{1'b1}});
   assign ext_x_s      = {{NB{x[Q-1]}}, x};

   // State register; reset aborts any run in progress.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; start is only honoured in IDLE or DONE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_s = ST_CLEAR;
            else       state_s = ST_IDLE;
         end
         ST_CLEAR: begin
            if (last_idx_s) state_s = ST_ACC;
            else            state_s = ST_CLEAR;
         end
         ST_ACC: begin
            if (x_valid && last_idx_s && last_frame_s) state_s = ST_DONE;
            else                                       state_s = ST_ACC;
         end
         ST_DONE: begin
            if (start) state_s = ST_CLEAR;
            else       state_s = ST_DONE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Output decode: status flags follow the next state so the registered copies align with the state.
   always_comb begin
      busy_s     = (state_s == ST_CLEAR) || (state_s == ST_ACC);
      done_s     = (state_s == ST_DONE);
      clear_we_s = (state_r == ST_CLEAR);
      acc_we_s   = (state_r == ST_ACC) && x_valid;
      rd_fire_s  = (state_r == ST_DONE) && rd_req;
   end

   // Bin index and frame counter; the index wraps naturally because M is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_r   <= {AW{1'b0}};
         frame_r <= {NB{1'b0}};
      end else begin
         case (state_r)
            ST_CLEAR: begin
               idx_r   <= idx_r + AW'(1);
               frame_r <= {NB{1'b0}};
            end
            ST_ACC: begin
               if (x_valid) begin
                  idx_r <= idx_r + AW'(1);
                  if (last_idx_s) begin
                     frame_r <= frame_r + NB'(1);
                  end
               end
            end
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  idx_r   <= {AW{1'b0}};
                  frame_r <= {NB{1'b0}};
               end
            end
            default: begin
               idx_r   <= {AW{1'b0}};
               frame_r <= {NB{1'b0}};
            end
         endcase
      end
   end

   // Accumulator array: cleared bin by bin, then read-modify-written per accepted sample; no reset.
   always_ff @(posedge clk) begin
      if (clear_we_s) begin
         mem_r[idx_r] <= {AW_ACC{1'b0}};
      end else if (acc_we_s) begin
         mem_r[idx_r] <= mem_r[idx_r] + ext_x_s;
      end
   end

   // Registered status and read port; rd_data holds its value between served reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         rd_valid_r <= 1'b0;
         rd_data_r  <= {AW_ACC{1'b0}};
      end else begin
         busy_r     <= busy_s;
         done_r     <= done_s;
         rd_valid_r <= rd_fire_s;
         if (rd_fire_s) begin
            rd_data_r <= mem_r[rd_addr];
         end
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign rd_valid = rd_valid_r;
   assign rd_data  = rd_data_r;

endmodule

// File: tb/tb_coherent_acc_buffer.sv
// Directed bench for coherent_acc_buffer: a small M=4/NB=2 instance for the
// functional scenarios and an M=4/NB=4 full-width instance for extremes.
module tb_coherent_acc_buffer;

   logic clk;
   logic reset_n;

   // Instance A: Q=16, M=4, NB=2
   logic               a_start, a_x_valid, a_busy, a_done, a_rd_req, a_rd_valid;
   logic signed [15:0] a_x;
   logic [1:0]         a_rd_addr;
   logic signed [17:0] a_rd_data;

   // Instance B: Q=32, M=4, NB=4
   logic               b_start, b_x_valid, b_busy, b_done, b_rd_req, b_rd_valid;
   logic signed [31:0] b_x;
   logic [1:0]         b_rd_addr;
   logic signed [35:0] b_rd_data;

   int checks;
   int failures;

   coherent_acc_buffer #(.Q(16), .M(4), .NB(2)) dut_a (
      .clk(clk), .reset_n(reset_n), .start(a_start), .x_valid(a_x_valid), .x(a_x),
      .busy(a_busy), .done(a_done), .rd_req(a_rd_req), .rd_addr(a_rd_addr),
      .rd_valid(a_rd_valid), .rd_data(a_rd_data)
   );

   coherent_acc_buffer #(.Q(32), .M(4), .NB(4)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(b_start), .x_valid(b_x_valid), .x(b_x),
      .busy(b_busy), .done(b_done), .rd_req(b_rd_req), .rd_addr(b_rd_addr),
      .rd_valid(b_rd_valid), .rd_data(b_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Feed 4 frames of the 4-value pattern to instance A, back to back.
   task automatic feed_a(input logic signed [15:0] v0, v1, v2, v3);
      logic signed [15:0] vals [4];
      vals = '{v0, v1, v2, v3};
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 4; i++) begin
            a_x       = vals[i];
            a_x_valid = 1'b1;
            tick();
         end
      end
      a_x_valid = 1'b0;
   endtask

   // Start pulse, wait out the 4-cycle clear, then feed a full run.
   task automatic run_a(input logic signed [15:0] v0, v1, v2, v3);
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      repeat (4) tick();
      feed_a(v0, v1, v2, v3);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      a_start = 1'b0; a_x_valid = 1'b0; a_x = 16'sd0; a_rd_req = 1'b0; a_rd_addr = 2'd0;
      b_start = 1'b0; b_x_valid = 1'b0; b_x = 32'sd0; b_rd_req = 1'b0; b_rd_addr = 2'd0;
      tick();
      tick();
      checks++;
      if (a_busy !== 1'b0 || a_done !== 1'b0 || a_rd_valid !== 1'b0 || a_rd_data !== 18'sd0) begin
         failures++;
         $display("FAIL reset_a busy=%b done=%b rd_valid=%b rd_data=%0d expected 0/0/0/0",
                  a_busy, a_done, a_rd_valid, a_rd_data);
      end
      checks++;
      if (b_busy !== 1'b0 || b_done !== 1'b0 || b_rd_valid !== 1'b0 || b_rd_data !== 36'sd0) begin
         failures++;
         $display("FAIL reset_b busy=%b done=%b rd_valid=%b rd_data=%0d expected 0/0/0/0",
                  b_busy, b_done, b_rd_valid, b_rd_data);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_idle_read();
      a_rd_req  = 1'b1;
      a_rd_addr = 2'd1;
      a_x_valid = 1'b1;
      a_x       = 16'sd7;
      tick();
      a_rd_req  = 1'b0;
      a_x_valid = 1'b0;
      checks++;
      if (a_rd_valid !== 1'b0 || a_rd_data !== 18'sd0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
         failures++;
         $display("FAIL idle_read rd_valid=%b rd_data=%0d busy=%b done=%b expected 0/0/0/0",
                  a_rd_valid, a_rd_data, a_busy, a_done);
      end
   endtask

   task automatic test_basic();
      logic signed [17:0] exp [4];
      exp = '{18'sd4, 18'sd8, 18'sd12, 18'sd16};
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      checks++;
      if (a_busy !== 1'b1 || a_done !== 1'b0) begin
         failures++;
         $display("FAIL basic_busy_after_start busy=%b done=%b expected 1/0", a_busy, a_done);
      end
      repeat (4) tick();
      feed_a(16'sd1, 16'sd2, 16'sd3, 16'sd4);
      checks++;
      if (a_done !== 1'b1 || a_busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_done done=%b busy=%b expected 1/0", a_done, a_busy);
      end
      // a sample offered in DONE must not disturb the results
      a_x = 16'sd100;
      a_x_valid = 1'b1;
      tick();
      a_x_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a_rd_req  = 1'b1;
         a_rd_addr = 2'(i);
         tick();
         checks++;
         if (a_rd_valid !== 1'b1 || a_rd_data !== exp[i]) begin
            failures++;
            $display("FAIL basic_read[%0d] rd_valid=%b rd_data=%0d expected 1/%0d",
                     i, a_rd_valid, a_rd_data, exp[i]);
         end
      end
      a_rd_req = 1'b0;
      tick();
      checks++;
      if (a_rd_valid !== 1'b0 || a_rd_data !== 18'sd16) begin
         failures++;
         $display("FAIL basic_read_idle rd_valid=%b rd_data=%0d expected 0/16", a_rd_valid, a_rd_data);
      end
   endtask

   task automatic test_ignore_in_acc();
      logic signed [15:0] vals [4];
      logic signed [17:0] exp [4];
      vals = '{16'sd10, 16'sd20, 16'sd30, 16'sd40};
      exp  = '{18'sd40, 18'sd80, 18'sd120, 18'sd160};
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      repeat (4) tick();
      for (int k = 0; k < 2; k++) begin
         a_x = vals[k]; a_x_valid = 1'b1; tick();
      end
      a_x_valid = 1'b0;
      a_start   = 1'b1;
      a_rd_req  = 1'b1;
      a_rd_addr = 2'd0;
      tick();
      a_start  = 1'b0;
      a_rd_req = 1'b0;
      checks++;
      if (a_rd_valid !== 1'b0 || a_rd_data !== 18'sd16 || a_busy !== 1'b1) begin
         failures++;
         $display("FAIL acc_ignore rd_valid=%b rd_data=%0d busy=%b expected 0/16/1",
                  a_rd_valid, a_rd_data, a_busy);
      end
      for (int k = 2; k < 16; k++) begin
         a_x = vals[k % 4]; a_x_valid = 1'b1; tick();
      end
      a_x_valid = 1'b0;
      checks++;
      if (a_done !== 1'b1) begin
         failures++;
         $display("FAIL acc_ignore_done done=%b expected 1", a_done);
      end
      for (int i = 0; i < 4; i++) begin
         a_rd_req = 1'b1; a_rd_addr = 2'(i); tick();
         checks++;
         if (a_rd_valid !== 1'b1 || a_rd_data !== exp[i]) begin
            failures++;
            $display("FAIL acc_ignore_read[%0d] rd_valid=%b rd_data=%0d expected 1/%0d",
                     i, a_rd_valid, a_rd_data, exp[i]);
         end
      end
      a_rd_req = 1'b0;
   endtask

   task automatic test_reset_mid_acc();
      logic signed [17:0] exp [4];
      exp = '{18'sd4, 18'sd8, 18'sd12, 18'sd16};
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      repeat (4) tick();
      for (int k = 0; k < 6; k++) begin
         a_x = 16'(k % 4 + 1); a_x_valid = 1'b1; tick();
      end
      a_x_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (a_busy !== 1'b0 || a_done !== 1'b0 || a_rd_valid !== 1'b0 || a_rd_data !== 18'sd0) begin
         failures++;
         $display("FAIL async_reset busy=%b done=%b rd_valid=%b rd_data=%0d expected 0/0/0/0",
                  a_busy, a_done, a_rd_valid, a_rd_data);
      end
      tick();
      reset_n = 1'b1;
      tick();
      checks++;
      if (a_busy !== 1'b0 || a_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_restart busy=%b done=%b expected 0/0", a_busy, a_done);
      end
      run_a(16'sd1, 16'sd2, 16'sd3, 16'sd4);
      for (int i = 0; i < 4; i++) begin
         a_rd_req = 1'b1; a_rd_addr = 2'(i); tick();
         checks++;
         if (a_rd_valid !== 1'b1 || a_rd_data !== exp[i]) begin
            failures++;
            $display("FAIL rerun_read[%0d] rd_valid=%b rd_data=%0d expected 1/%0d",
                     i, a_rd_valid, a_rd_data, exp[i]);
         end
      end
      a_rd_req = 1'b0;
   endtask

   task automatic test_read_with_start();
      logic signed [17:0] exp [4];
      exp = '{18'sd20, 18'sd24, 18'sd28, 18'sd32};
      a_rd_req  = 1'b1;
      a_rd_addr = 2'd2;
      a_start   = 1'b1;
      tick();
      a_rd_req = 1'b0;
      a_start  = 1'b0;
      checks++;
      if (a_rd_valid !== 1'b1 || a_rd_data !== 18'sd12 || a_busy !== 1'b1 || a_done !== 1'b0) begin
         failures++;
         $display("FAIL read_start rd_valid=%b rd_data=%0d busy=%b done=%b expected 1/12/1/0",
                  a_rd_valid, a_rd_data, a_busy, a_done);
      end
      repeat (4) tick();
      feed_a(16'sd5, 16'sd6, 16'sd7, 16'sd8);
      for (int i = 0; i < 4; i++) begin
         a_rd_req = 1'b1; a_rd_addr = 2'(i); tick();
         checks++;
         if (a_rd_valid !== 1'b1 || a_rd_data !== exp[i]) begin
            failures++;
            $display("FAIL read_start_rerun[%0d] rd_valid=%b rd_data=%0d expected 1/%0d",
                     i, a_rd_valid, a_rd_data, exp[i]);
         end
      end
      a_rd_req = 1'b0;
   endtask

   task automatic test_busy_window();
      int busy_cnt;
      int t;
      busy_cnt = 0;
      t = 0;
      a_x = -16'sd5;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      // x_valid toggles from the start pulse onward; it is high on the first ACC cycle
      while (a_busy === 1'b1 && t < 100) begin
         busy_cnt++;
         a_x_valid = (t % 2 == 0);
         tick();
         t++;
      end
      a_x_valid = 1'b0;
      checks++;
      if (busy_cnt !== 35 || a_done !== 1'b1) begin
         failures++;
         $display("FAIL busy_window busy_cycles=%0d done=%b expected 35/1", busy_cnt, a_done);
      end
      for (int i = 0; i < 4; i++) begin
         a_rd_req = 1'b1; a_rd_addr = 2'(i); tick();
         checks++;
         if (a_rd_valid !== 1'b1 || a_rd_data !== -18'sd20) begin
            failures++;
            $display("FAIL neg_read[%0d] rd_valid=%b rd_data=%0d expected 1/-20",
                     i, a_rd_valid, a_rd_data);
         end
      end
      a_rd_req = 1'b0;
   endtask

   task automatic test_extremes();
      logic signed [31:0] xv [2];
      logic signed [35:0] ev [2];
      xv = '{32'sh7FFF_FFFF, 32'sh8000_0000};
      ev = '{36'sh7_FFFF_FFF0, 36'sh8_0000_0000};
      for (int r = 0; r < 2; r++) begin
         b_start = 1'b1;
         tick();
         b_start = 1'b0;
         repeat (4) tick();
         b_x = xv[r];
         for (int k = 0; k < 64; k++) begin
            b_x_valid = 1'b1;
            tick();
         end
         b_x_valid = 1'b0;
         checks++;
         if (b_done !== 1'b1 || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL extreme_done[%0d] done=%b busy=%b expected 1/0", r, b_done, b_busy);
         end
         for (int i = 0; i < 4; i++) begin
            b_rd_req = 1'b1; b_rd_addr = 2'(i); tick();
            checks++;
            if (b_rd_valid !== 1'b1 || b_rd_data !== ev[r]) begin
               failures++;
               $display("FAIL extreme_read[%0d][%0d] rd_valid=%b rd_data=%h expected 1/%h",
                        r, i, b_rd_valid, b_rd_data, ev[r]);
            end
         end
         b_rd_req = 1'b0;
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_idle_read();
      test_basic();
      test_ignore_in_acc();
      test_reset_mid_acc();
      test_read_with_start();
      test_busy_window();
      test_extremes();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/coherent_acc_buffer.md
COHERENT_ACC_BUFFER -- requirements
Module: coherent_acc_buffer

Interface
REQ-001 Parameter Q, default 32, input sample width in bits (signed two's complement).
REQ-002 Parameter M, default 128, samples per frame (power of two, >= 2); AW = clog2(M).
REQ-003 Parameter NB, default 4; frames averaged N = 2^NB; accumulator width AW_ACC = Q+NB.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; begins a new accumulation run.
REQ-007 x_valid  input  1  qualifies x for one sample.
REQ-008 x  input  Q  signed sample.
REQ-009 busy  output  1  high in CLEAR and ACC states.
REQ-010 done  output  1  high in DONE state.
REQ-011 rd_req  input  1  read request from the fetch side.
REQ-012 rd_addr  input  AW  bin index to read.
REQ-013 rd_valid  output  1  read data valid strobe.
REQ-014 rd_data  output  Q+NB  signed accumulated bin value.

Function
REQ-015 The block SHALL hold an M-entry array of signed (Q+NB)-bit accumulators.
REQ-016 The FSM SHALL have states IDLE, CLEAR, ACC, DONE; state after reset is IDLE.
REQ-017 IDLE or DONE + start -> CLEAR; start in CLEAR/ACC SHALL be ignored.
REQ-018 CLEAR SHALL write zero to bin 0..M-1, one bin per cycle (exactly M cycles), then enter ACC with bin index 0, frame count 0.
REQ-019 In ACC each cycle with x_valid=1 SHALL update bin[idx] <= bin[idx] + sign-extended x, then advance idx; cycles with x_valid=0 SHALL change nothing.
REQ-020 idx SHALL wrap M-1 -> 0; each wrap SHALL increment frame count.
REQ-021 On the sample that wraps idx with frame count N-1, the FSM SHALL enter DONE on the next edge; no further samples accepted.
REQ-022 Accumulation SHALL be full-width, no saturation; Q+NB bits guarantee no overflow for N frames.
REQ-023 x_valid outside ACC SHALL be ignored.
REQ-024 In DONE, rd_req=1 SHALL yield rd_valid=1 and rd_data=bin[rd_addr] exactly one cycle later; back-to-back requests SHALL be served every cycle.
REQ-025 rd_req outside DONE SHALL be ignored: rd_valid=0 next cycle, rd_data holds its previous value.
REQ-026 rd_req and start in the same DONE cycle: the read SHALL be served (from pre-clear contents), then the FSM enters CLEAR.
REQ-027 busy and done SHALL be registered and mutually exclusive.

Reset
REQ-028 reset_n=0 SHALL immediately force: state IDLE, busy=0, done=0, rd_valid=0, rd_data=0, idx=0, frame count=0.
REQ-029 Accumulator contents SHALL NOT be reset; they are undefined until the next CLEAR completes.
REQ-030 Reset asserted mid-CLEAR or mid-ACC SHALL abort the run; a new start is required.

Verification
REQ-031 M=4, NB=2: start, wait 4 cycles, feed x=1,2,3,4 for 4 frames -> done=1; reads of addr 0..3 return 4,8,12,16 one cycle after each rd_req.
REQ-032 M=4, NB=2: x=-5 constant for 16 samples with x_valid toggling every other cycle -> all bins read -20; busy high for exactly 4 + 31 cycles.
REQ-033 Q=32, NB=4: x=32'h7FFFFFFF for all samples -> bin = 16*(2^31-1) = 36'h7_FFFF_FFF0, no wrap; x=32'h80000000 -> 36'h8_0000_0000.
REQ-034 rd_req pulsed in IDLE and during ACC -> rd_valid stays 0, rd_data unchanged; start pulsed during ACC -> run unaffected.
REQ-035 Assert reset_n=0 mid-ACC (frame 1, idx 2) -> busy/done/rd_valid drop asynchronously; after release, start runs a full clean cycle and REQ-031 values are reproduced.
REQ-036 In DONE, rd_req with start in the same cycle -> correct old bin value returned, busy=1 next cycle, subsequent run results correct.
